// File: rtl/param_delay_line.sv
// Runtime-programmable sample delay line built on one circular buffer of MAX_DEPTH words.
// Optional feedback echo path is compiled in when DLY_ECHO_EN is defined (adds echo_on port).
module param_delay_line #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned MAX_DEPTH   = 90,
    parameter int unsigned DSEL_W      = 7,
    parameter int unsigned DEFAULT_DLY = 30,
    parameter int unsigned ECHO_SHIFT  = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              en,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DSEL_W-1:0] delay,
    input  logic              delay_load,
    input  logic              flush,
`ifdef DLY_ECHO_EN
    input  logic              echo_on,
`endif
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              delay_err
);

    localparam logic [DSEL_W-1:0] MAX_W = DSEL_W'(MAX_DEPTH);
    localparam logic [DSEL_W-1:0] DEF_W = DSEL_W'(DEFAULT_DLY);

    if (MAX_DEPTH < 2 || (2 ** DSEL_W) <= MAX_DEPTH || DEFAULT_DLY < 1 ||
        DEFAULT_DLY > MAX_DEPTH || ECHO_SHIFT >= DATA_W) begin : g_param_check
        $error("param_delay_line: inconsistent parameter set");
    end

    logic [DATA_W-1:0] mem [MAX_DEPTH];
    logic [DSEL_W-1:0] wp;
    logic [DSEL_W-1:0] fill;
    logic [DSEL_W-1:0] active_dly;
    logic [DSEL_W-1:0] rd_addr;
    logic [DSEL_W-1:0] wp_next;
    logic [DSEL_W-1:0] fill_next;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] wr_word;
    logic              rd_valid;
    logic              delay_legal;

    // Modular subtraction without a wider intermediate: MAX_W - D never underflows for a legal D.
    always_comb begin
        rd_addr = '0;
        if (wp >= active_dly) begin
            rd_addr = wp - active_dly;
        end else begin
            rd_addr = wp + (MAX_W - active_dly);
        end
    end

    always_comb begin
        rd_word     = mem[rd_addr];
        rd_valid    = (fill >= active_dly);
        wp_next     = (wp == MAX_W - 1'b1) ? '0 : wp + 1'b1;
        fill_next   = (fill == MAX_W) ? fill : fill + 1'b1;
        delay_legal = (delay != '0) && (delay <= MAX_W);
    end

`ifdef DLY_ECHO_EN
    logic [DATA_W-1:0] fb;
    logic [DATA_W:0]   echo_sum;

    always_comb begin
        fb       = rd_valid ? rd_word : '0;
        echo_sum = {1'b0, data_in} + {1'b0, fb >> ECHO_SHIFT};
        wr_word  = data_in;
        if (echo_on) begin
            wr_word = echo_sum[DATA_W] ? '1 : echo_sum[DATA_W-1:0];
        end
    end
`else
    always_comb begin
        wr_word = data_in;
    end
`endif

    // Storage is never reset; reset_n gates the write so an edge during reset cannot corrupt it.
    always_ff @(posedge clock) begin
        if (reset_n && en && !flush) begin
            mem[wp] <= wr_word;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wp         <= '0;
            fill       <= '0;
            active_dly <= DEF_W;
            data_out   <= '0;
            out_valid  <= 1'b0;
            delay_err  <= 1'b0;
        end else begin
            delay_err <= delay_load && !delay_legal;
            if (delay_load && delay_legal) begin
                active_dly <= delay;
            end
            if (flush) begin
                wp        <= '0;
                fill      <= '0;
                data_out  <= '0;
                out_valid <= 1'b0;
            end else if (en) begin
                data_out  <= rd_valid ? rd_word : '0;
                out_valid <= rd_valid;
                wp        <= wp_next;
                fill      <= fill_next;
            end
        end
    end

endmodule

// File: tb/tb_param_delay_line.sv
// Scoreboard bench for param_delay_line: driver queues expected outputs, monitor pops on each en edge.
// Echo vectors are included only when DLY_ECHO_EN is defined.
module tb_param_delay_line;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned MAX_DEPTH   = 90;
    localparam int unsigned DSEL_W      = 7;
    localparam int unsigned DEFAULT_DLY = 30;

    logic              clock      = 1'b0;
    logic              reset_n    = 1'b0;
    logic              en         = 1'b0;
    logic              delay_load = 1'b0;
    logic              flush      = 1'b0;
    logic [DATA_W-1:0] data_in    = '0;
    logic [DSEL_W-1:0] delay      = '0;
`ifdef DLY_ECHO_EN
    logic              echo_on    = 1'b0;
`endif
    logic [DATA_W-1:0] data_out;
    logic              out_valid;
    logic              delay_err;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [8:0] sb[$];
    int         hist[$];
    int         model_d = DEFAULT_DLY;
    logic [8:0] last_exp = '0;
    logic [8:0] exp_hold;
    bit         fire = 1'b0;

    param_delay_line #(
        .DATA_W     (DATA_W),
        .MAX_DEPTH  (MAX_DEPTH),
        .DSEL_W     (DSEL_W),
        .DEFAULT_DLY(DEFAULT_DLY),
        .ECHO_SHIFT (1)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .en        (en),
        .data_in   (data_in),
        .delay     (delay),
        .delay_load(delay_load),
        .flush     (flush),
`ifdef DLY_ECHO_EN
        .echo_on   (echo_on),
`endif
        .data_out  (data_out),
        .out_valid (out_valid),
        .delay_err (delay_err)
    );

    always #5 clock = ~clock;

    // A sample advance happened on this edge: its result is checked on the following negedge.
    always @(posedge clock) fire <= en && !flush && reset_n;

    always @(negedge clock) begin
        if (fire) begin
            logic [8:0] e;
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_underflow: got valid=%0b data=%0d, required no output", out_valid, data_out);
            end else begin
                e = sb.pop_front();
                if ({out_valid, data_out} !== e) begin
                    n_bad++;
                    $display("FAIL stream @%0t: got valid=%0b data=%0d, required valid=%0b data=%0d",
                             $time, out_valid, data_out, e[8], e[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d, required %0d", name, $time, act, req);
        end
    endtask

    task automatic step(input bit e, input logic [7:0] d, input bit fl, input bit ld,
                        input logic [6:0] dv);
        en = e; data_in = d; flush = fl; delay_load = ld; delay = dv;
        if (e && !fl) begin
            if (hist.size() >= model_d) last_exp = {1'b1, 8'(hist[hist.size() - model_d])};
            else                        last_exp = '0;
            sb.push_back(last_exp);
            hist.push_back(int'(d));
        end
        if (fl) begin
            hist.delete();
            last_exp = '0;
        end
        if (ld && dv != 0 && int'(dv) <= MAX_DEPTH) model_d = int'(dv);
        @(posedge clock);
        #1;
        en = 1'b0; flush = 1'b0; delay_load = 1'b0;
    endtask

    task automatic step_exp(input logic [7:0] d, input logic [8:0] e);
        en = 1'b1; data_in = d;
        sb.push_back(e);
        @(posedge clock);
        #1;
        en = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("reset_out", {out_valid, data_out}, 9'd0);
        check("reset_err", 9'(delay_err), 9'd0);
        reset_n = 1'b1;

        // Prime at default delay 30, flush coincident with sample 50, then re-prime.
        for (int i = 1; i <= 49; i++) step(1'b1, 8'(i), 1'b0, 1'b0, '0);
        step(1'b1, 8'd50, 1'b1, 1'b0, '0);
        check("flush_out", {out_valid, data_out}, 9'd0);
        for (int i = 51; i <= 100; i++) step(1'b1, 8'(i), 1'b0, 1'b0, '0);

        // Illegal delays pulse delay_err and leave D at 30.
        step(1'b0, '0, 1'b0, 1'b1, 7'd0);
        check("err_zero", 9'(delay_err), 9'd1);
        step(1'b0, '0, 1'b0, 1'b0, '0);
        check("err_pulse_end", 9'(delay_err), 9'd0);
        step(1'b0, '0, 1'b0, 1'b1, 7'd91);
        check("err_91", 9'(delay_err), 9'd1);
        step(1'b0, '0, 1'b0, 1'b0, '0);
        check("err_pulse_end2", 9'(delay_err), 9'd0);
        for (int i = 101; i <= 105; i++) step(1'b1, 8'(i), 1'b0, 1'b0, '0);

        // Maximum delay over three pointer wraps, loaded together with a flush.
        step(1'b0, '0, 1'b1, 1'b1, 7'd90);
        check("err_legal", 9'(delay_err), 9'd0);
        for (int i = 1; i <= 300; i++) step(1'b1, 8'(i), 1'b0, 1'b0, '0);

        step(1'b0, '0, 1'b0, 1'b1, 7'd10);
        for (int i = 301; i <= 320; i++) step(1'b1, 8'(i), 1'b0, 1'b0, '0);
        step(1'b0, '0, 1'b0, 1'b1, 7'd1);
        for (int i = 321; i <= 330; i++) step(1'b1, 8'(i), 1'b0, 1'b0, '0);

        // Gapped enables with D=4; output must hold across idle clocks.
        step(1'b0, '0, 1'b1, 1'b1, 7'd4);
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 8'(k * 3), 1'b0, 1'b0, '0);
            exp_hold = last_exp;
            step(1'b0, 8'hAA, 1'b0, 1'b0, '0);
            step(1'b0, 8'h55, 1'b0, 1'b0, '0);
            check("idle_hold", {out_valid, data_out}, exp_hold);
        end

        // Asynchronous reset mid-stream restores the default delay.
        step(1'b0, '0, 1'b1, 1'b1, 7'd12);
        for (int i = 1; i <= 40; i++) step(1'b1, 8'(i), 1'b0, 1'b0, '0);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", {out_valid, data_out}, 9'd0);
        hist.delete();
        model_d = DEFAULT_DLY;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 1; i <= 35; i++) step(1'b1, 8'(i + 200), 1'b0, 1'b0, '0);

`ifdef DLY_ECHO_EN
        echo_on = 1'b1;
        step(1'b0, '0, 1'b1, 1'b1, 7'd2);
        step_exp(8'd100, 9'd0);
        step_exp(8'd0,   9'd0);
        step_exp(8'd0,   {1'b1, 8'd100});
        step_exp(8'd0,   {1'b1, 8'd0});
        step_exp(8'd0,   {1'b1, 8'd50});
        step_exp(8'd0,   {1'b1, 8'd0});
        step_exp(8'd0,   {1'b1, 8'd25});
        step_exp(8'd0,   {1'b1, 8'd0});
        step(1'b0, '0, 1'b1, 1'b0, '0);
        step_exp(8'd255, 9'd0);
        step_exp(8'd255, 9'd0);
        for (int i = 0; i < 6; i++) step_exp(8'd255, {1'b1, 8'd255});
        echo_on = 1'b0;
`endif

        @(negedge clock);
        #1;
        check("sb_drain", 9'(sb.size()), 9'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
